// File: rtl/serial_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_sub_pkg
// Shared definitions for the bit-serial adder/subtractor:
//   - WIDTH_DEFAULT : default operand/result width
//   - state_t       : control FSM states (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package serial_add_sub_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sub_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Purely combinational 1-bit full adder used as the serial arithmetic core.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial adder/subtractor. One operand bit pair is processed per clock,
// LSB first, through a single full_adder_cell. Subtraction is a + ~b + 1:
// b is inverted at load time and the carry flop is seeded with 1.
// An operation takes WIDTH RUN cycles followed by one DONE cycle.
//
// Optional feature: define SERIAL_ADD_SUB_OVF_EN to add the signed-overflow
// output ovf (carry into MSB XOR carry out of MSB).
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request an operation (sampled only in IDLE)
//   sub   : 0 = a+b, 1 = a-b (sampled with start)
//   a, b  : operands (sampled with start)
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse with a new valid result
//   f     : result, held until the next done
//   cout  : carry out of the MSB (for subtract, 1 = no borrow)
//   ovf   : signed overflow (only with SERIAL_ADD_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Upper WIDTH-1 bits of the result shift register; the final sum bit is
  // merged in directly when the result is published.
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_out;
  logic             last_bit;

  full_adder_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (carry_out)
  );

  assign res_next = {sum_bit, res_sh};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Control FSM and published outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      f     <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (last_bit) begin
            state <= DONE;
            done  <= 1'b1;
            f     <= res_next;
            cout  <= carry_out;
`ifdef SERIAL_ADD_SUB_OVF_EN
            // carry holds the carry into the MSB on the last RUN cycle.
            ovf   <= carry ^ carry_out;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Serial datapath.
  // NOTE: these registers carry no reset; every operation loads them on the
  // start-accept edge before any of their contents are used.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub;  // +1 of the two's-complement subtract
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next[WIDTH-1:1];
      carry  <= carry_out;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit: operation select, 0 = A+B, 1 = A-B; sampled with start.
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands; sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port f, output, WIDTH bits: the result.
REQ-010 The block SHALL have port cout, output, 1 bit: final carry-out (for subtract, 1 = no borrow).
REQ-011 The block SHALL have port ovf, output, 1 bit: signed overflow; present only with the macro of REQ-024.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a, b (inverted when sub=1) and sub into shift registers, set the carry flop to sub, clear the bit counter, and go to RUN.
REQ-014 In RUN, each cycle SHALL add bit 0 of both operand registers plus the carry flop in one full-adder cell, shift the sum bit into the MSB of the result register, store the cell carry-out, shift both operand registers right, and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH cycles; after the cycle with counter = WIDTH-1 the FSM SHALL go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; latency from the start-accept edge to done high is WIDTH+1 cycles.
REQ-017 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-018 f, cout and ovf SHALL hold their last completed values until the next done pulse; they SHALL NOT change while in RUN.
REQ-019 start asserted in RUN or DONE SHALL be ignored, with no queueing; start held high continuously SHALL start a new operation on the first IDLE cycle after DONE.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; cout is the carry out of bit WIDTH-1; a-b is computed as a + ~b + 1.

Reset
REQ-021 With rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done, f, cout and ovf SHALL all become 0, regardless of state.
REQ-022 A reset during RUN SHALL abort the operation; no done pulse is produced for it.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 With SERIAL_ADD_SUB_OVF_EN defined, the block SHALL provide port ovf = carry-into-MSB XOR carry-out-of-MSB, captured on the last RUN cycle; without the macro, the ovf port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-025 Package serial_add_sub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the WIDTH_DEFAULT=8 constant.
REQ-026 The 1-bit add SHALL be done by one instance of sub-module full_adder_cell (inputs a, b, ci; outputs s, co), which is purely combinational.

Verification (WIDTH=8)
REQ-027 Reset, then start with a=8'h05, b=8'h03, sub=0 -> busy high for 9 cycles, done pulse on cycle 9, f=8'h08, cout=0, ovf=0.
REQ-028 a=8'hFF, b=8'h01, sub=0 -> f=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01, sub=0 -> f=8'h80, ovf=1.
REQ-029 a=8'h03, b=8'h05, sub=1 -> f=8'hFE, cout=0; a=8'h80, b=8'h01, sub=1 -> f=8'h7F, cout=1, ovf=1.
REQ-030 Pulse start again at RUN cycle 3 with different operands -> ignored; result matches the first operands and f is unchanged until done.
REQ-031 Assert rst at RUN cycle 4 -> next cycle IDLE, all outputs 0, no done; a fresh start afterwards completes correctly.
REQ-032 Hold start high for 30 cycles -> back-to-back operations, each producing done every 10 cycles.
